oam_dma_ctrl: RTL and testbench



---
 rtl/oam_dma_ctrl_pkg.sv | 25 ++
 rtl/oam_dma_ctrl.sv | 103 ++++++++++
 tb/tb_oam_dma_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/oam_dma_ctrl_pkg.sv
// Shared encodings for the sprite DMA sequencer: bus rw levels, register addresses, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package oam_dma_ctrl_pkg;

    // rw pin encoding shared by the CPU and the system bus
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Default register addresses in the NES memory map
    localparam logic [15:0] DMA_REG  = 16'h4014;
    localparam logic [15:0] OAM_DATA = 16'h2004;

    // Bytes per transfer; tied to the 8-bit index counter wrapping
    localparam int XFER_LEN = 256;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4
    } dma_state_t;

endpackage

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA bus sequencer: halts the CPU and copies one 256-byte page to the OAM data port.
// Latency: 513 or 514 halted cycles per transfer depending on get/put alignment.
// Backpressure: the CPU is held through cpu_rdy=0 for the whole transfer; the bus is never stalled.
module oam_dma_ctrl
    import oam_dma_ctrl_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR  = DMA_REG,
    parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_d_out,
    input  logic        cpu_rw,
    output logic [7:0]  cpu_d_in,
    output logic        cpu_rdy,
    output logic [15:0] bus_a,
    output logic [7:0]  bus_d_out,
    output logic        bus_rw,
    input  logic [7:0]  bus_d_in,
    output logic        dma_active
);

    dma_state_t state_q;
    logic       parity_q;   // 0 = get cycle, 1 = put cycle
    logic [7:0] idx_q;
    logic [7:0] idx_d;
    logic [7:0] page_q;
    logic [7:0] data_q;

    assign idx_d = idx_q + 8'd1;

    // Transfer sequencer: get/put parity, page/index bookkeeping and state walk
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            parity_q <= 1'b0;
            idx_q    <= 8'd0;
            page_q   <= 8'd0;
            data_q   <= 8'd0;
        end else begin
            parity_q <= ~parity_q;
            case (state_q)
                ST_IDLE: begin
                    // The triggering CPU write still reaches the bus this cycle
                    if (cpu_rw == RW_WRITE && cpu_a == DMA_REG_ADDR) begin
                        page_q  <= cpu_d_out;
                        state_q <= ST_HALT;
                    end
                end
                ST_HALT: begin
                    // Reads must land on get cycles; burn one extra cycle if misaligned
                    state_q <= parity_q ? ST_READ : ST_ALIGN;
                end
                ST_ALIGN: begin
                    state_q <= ST_READ;
                end
                ST_READ: begin
                    data_q  <= bus_d_in;
                    state_q <= ST_WRITE;
                end
                ST_WRITE: begin
                    idx_q   <= idx_d;
                    state_q <= (idx_q == 8'hFF) ? ST_IDLE : ST_READ;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Bus ownership mux: CPU passthrough in IDLE, dummy reads while aligning, copy traffic otherwise
    always_comb begin
        bus_a      = cpu_a;
        bus_rw     = RW_READ;
        bus_d_out  = data_q;
        cpu_rdy    = 1'b0;
        dma_active = 1'b1;
        case (state_q)
            ST_IDLE: begin
                bus_rw     = cpu_rw;
                bus_d_out  = cpu_d_out;
                cpu_rdy    = 1'b1;
                dma_active = 1'b0;
            end
            ST_READ: begin
                bus_a = {page_q, idx_q};
            end
            ST_WRITE: begin
                bus_a  = OAM_DATA_ADDR;
                bus_rw = RW_WRITE;
            end
            default: begin
                // HALT / ALIGN: dummy read at whatever address the stalled CPU presents
                bus_a = cpu_a;
            end
        endcase
    end

    assign cpu_d_in = bus_d_in;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Randomized scoreboard bench for the sprite DMA sequencer against a page-copy reference model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_oam_dma_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_d_out;
    logic        cpu_rw;
    logic [7:0]  cpu_d_in;
    logic        cpu_rdy;
    logic [15:0] bus_a;
    logic [7:0]  bus_d_out;
    logic        bus_rw;
    logic [7:0]  bus_d_in;
    logic        dma_active;

    logic [7:0]  mem [0:65535];
    assign bus_d_in = mem[bus_a];

    oam_dma_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_a      (cpu_a),
        .cpu_d_out  (cpu_d_out),
        .cpu_rw     (cpu_rw),
        .cpu_d_in   (cpu_d_in),
        .cpu_rdy    (cpu_rdy),
        .bus_a      (bus_a),
        .bus_d_out  (bus_d_out),
        .bus_rw     (bus_rw),
        .bus_d_in   (bus_d_in),
        .dma_active (dma_active)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_dma_wr = 0;
    int cyc = 0;           // cycles since reset; bit 0 is the get/put parity
    int halt_run = 0;

    logic [15:0] exp_rd_q [$];
    logic [23:0] exp_wr_q [$];
    int          exp_halt_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Monitor: checks bus traffic against the expectation queues
    always @(negedge clk) begin
        if (!rst) begin
            chk("cpu_d_in_follows_bus", {24'd0, cpu_d_in}, {24'd0, bus_d_in});
            if (!dma_active) begin
                chk("idle_bus_a",    {16'd0, bus_a},     {16'd0, cpu_a});
                chk("idle_bus_rw",   {31'd0, bus_rw},    {31'd0, cpu_rw});
                chk("idle_bus_dout", {24'd0, bus_d_out}, {24'd0, cpu_d_out});
            end else if (bus_rw == 1'b0) begin
                n_dma_wr++;
                if (exp_wr_q.size() == 0) chk("unexpected_dma_write", {8'd0, bus_a, bus_d_out}, 32'd0);
                else chk("dma_write", {8'd0, bus_a, bus_d_out}, {8'd0, exp_wr_q.pop_front()});
            end else if (bus_a != cpu_a) begin
                if (exp_rd_q.size() == 0) chk("unexpected_dma_read", {16'd0, bus_a}, 32'd0);
                else chk("dma_read_addr", {16'd0, bus_a}, {16'd0, exp_rd_q.pop_front()});
            end
        end
    end

    // Monitor: measures each contiguous cpu_rdy-low run
    always @(negedge clk) begin
        if (rst) begin
            halt_run = 0;
        end else if (!cpu_rdy) begin
            halt_run++;
        end else if (halt_run > 0) begin
            if (exp_halt_q.size() == 0) chk("unexpected_halt", halt_run, 0);
            else chk("halt_length", halt_run, exp_halt_q.pop_front());
            halt_run = 0;
        end
    end

    // Wait until the current cycle has the requested parity (called at posedge+#1)
    task automatic align_to(input int p);
        while (cyc[0] != p[0]) begin
            @(posedge clk); #1;
        end
    endtask

    // Issue the start write in the current cycle and queue the expected transfer
    task automatic do_start(input logic [7:0] page);
        cpu_a = 16'h4014; cpu_rw = 1'b0; cpu_d_out = page;
        // HALT follows on the opposite parity; a put-parity HALT skips the align cycle
        exp_halt_q.push_back((cyc[0] == 1'b0) ? 513 : 514);
        for (int i = 0; i < 256; i++) begin
            logic [15:0] a;
            a = {page, i[7:0]};
            exp_rd_q.push_back(a);
            exp_wr_q.push_back({16'h2004, mem[a]});
        end
        @(posedge clk); #1;
        cpu_rw = 1'b1;
        cpu_d_out = 8'h00;
    endtask

    task automatic wait_done(input bit intrude);
        int k;
        k = 0;
        while (!cpu_rdy && k < 600) begin
            @(posedge clk); #1;
            k++;
            if (intrude && k == 10) begin
                cpu_rw = 1'b0; cpu_d_out = 8'h5A;
            end
            if (intrude && k == 11) cpu_rw = 1'b1;
        end
        if (!cpu_rdy) begin
            chk("transfer_timeout", 0, 1);
        end else begin
            chk("done_dma_active", {31'd0, dma_active}, 0);
            chk("done_idx_zero", {24'd0, dut.idx_q}, 0);
            chk("done_rd_q_empty", exp_rd_q.size(), 0);
            chk("done_wr_q_empty", exp_wr_q.size(), 0);
        end
    endtask

    initial begin
        logic [7:0] pg;
        int base;

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0300 + i] = 8'(i) ^ 8'hA5;

        rst = 1'b1; cpu_a = 16'h0000; cpu_rw = 1'b1; cpu_d_out = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("reset_cpu_rdy", {31'd0, cpu_rdy}, 1);
        chk("reset_dma_active", {31'd0, dma_active}, 0);
        chk("reset_idx", {24'd0, dut.idx_q}, 0);
        chk("reset_bus_rw", {31'd0, bus_rw}, 1);

        // Passthrough: neighbouring register write and DMA register read
        for (int n = 0; n < 24; n++) begin
            @(posedge clk); #1;
            case (n % 3)
                0: begin cpu_a = 16'h4013; cpu_rw = 1'b0; end
                1: begin cpu_a = 16'h4014; cpu_rw = 1'b1; end
                default: begin cpu_a = 16'($urandom_range(0, 16'h3FFF)); cpu_rw = 1'($urandom); end
            endcase
            cpu_d_out = 8'($urandom);
            @(negedge clk);
            chk("pass_cpu_rdy", {31'd0, cpu_rdy}, 1);
            chk("pass_dma_active", {31'd0, dma_active}, 0);
        end
        @(posedge clk); #1;
        cpu_rw = 1'b1; cpu_a = 16'h4014;

        // HALT on put parity (513 cycles), then on get parity (514 cycles)
        align_to(0); do_start(8'h02); wait_done(1'b0);
        @(posedge clk); #1;
        align_to(1); do_start(8'h02); wait_done(1'b0);

        // Data pattern page, then a back-to-back start in the first IDLE cycle
        @(posedge clk); #1;
        align_to(int'($urandom_range(0, 1)));
        do_start(8'h03); wait_done(1'b0);
        do_start(8'h07); wait_done(1'b0);

        // Random pages and alignment; one with a CPU write to the DMA register mid-transfer
        for (int t = 0; t < 3; t++) begin
            @(posedge clk); #1;
            pg = 8'($urandom);
            if (pg == 8'h40) pg = 8'h41;
            align_to(int'($urandom_range(0, 1)));
            do_start(pg); wait_done(t == 1);
        end

        // Reset after the 40th OAM write aborts the transfer
        @(posedge clk); #1;
        base = n_dma_wr;
        do_start(8'h05);
        for (int k = 0; k < 200 && (n_dma_wr - base) < 40; k++) begin
            @(posedge clk); #1;
        end
        chk("abort_reached_40", n_dma_wr - base, 40);
        rst = 1'b1;
        exp_rd_q.delete(); exp_wr_q.delete(); exp_halt_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_cpu_rdy", {31'd0, cpu_rdy}, 1);
        chk("abort_dma_active", {31'd0, dma_active}, 0);
        chk("abort_bus_a", {16'd0, bus_a}, {16'd0, cpu_a});
        chk("abort_bus_rw", {31'd0, bus_rw}, {31'd0, cpu_rw});
        repeat (20) @(posedge clk);
        #1;
        chk("abort_no_more_writes", n_dma_wr - base, 40);
        chk("final_halt_q_empty", exp_halt_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
